// File: rtl/uart_io_pll_pkg.sv
// Shared types and default constants for the UART_IO PLL reset/lock supervisor.
package uart_io_pll_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT       = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES        = 3;
    localparam int unsigned DEF_CNT_W              = 16;

    localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/uart_io_sync2.sv
// Generic two-flop bit synchronizer; both stages reset to 0.
module uart_io_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_io_pll_rst_ctrl.sv
// PLL power-up/lock supervisor: pulses pll_rst, waits for lock with timeout and
// bounded retries, qualifies lock stability, then releases the system reset request.
module uart_io_pll_rst_ctrl
    import uart_io_pll_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES        = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_req,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    pll_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic             locked_s;

    uart_io_sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock is checked first so it wins over a timeout on the same cycle.
                if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = HOLD;
                        retry_nxt = retry_cnt + 2'd1;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = HOLD;
                    retry_nxt = '0;
                    if (lock_loss_cnt != LOSS_CNT_MAX) begin
                        loss_nxt = lock_loss_cnt + 8'd1;
                    end
                end else if (relock_req) begin
                    state_nxt = HOLD;
                    retry_nxt = '0;
                end
            end
            FAULT: begin
                cnt_nxt = '0;
                if (relock_req) begin
                    state_nxt = HOLD;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= HOLD;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst_req   <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            // Outputs decode the next state so they switch on the same edge as the state.
            pll_rst       <= (state_nxt == HOLD) || (state_nxt == FAULT);
            sys_rst_req   <= (state_nxt != RUN);
            ready         <= (state_nxt == RUN);
            fault         <= (state_nxt == FAULT);
        end
    end

endmodule

// File: doc/uart_io_pll_rst_ctrl.md
Name: uart_io_pll_rst_ctrl

Overview:
- Power-up and lock supervisor for the UART_IO system PLL (50 MHz ref, 100 MHz out).
- Holds the PLL in reset for a minimum pulse, waits for lock with a timeout, and retries a bounded number of times.
- Qualifies lock as stable before releasing the system reset request, and re-runs the sequence on loss of lock.
- Runs entirely on the free-running reference clock. Sits between the board clock/reset pins and the PLL wrapper plus the system reset tree.

Parameters:
- RST_HOLD_CYCLES, 16, refclk cycles that pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK per attempt (1 ms at 50 MHz, >=2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before ready (>=1).
- MAX_RETRIES, 3, extra attempts after the first before FAULT (0..3).
- CNT_W, 16, width of the shared cycle counter; must hold max(all cycle parameters)-1.

Ports:
- refclk  in  1  reference clock (50 MHz); the only clock.
- rst  in  1  reset, asynchronous, active-high.
- pll_locked  in  1  PLL locked, asynchronous to refclk; 2-flop synchronized inside to give locked_s.
- relock_req  in  1  single-cycle software request to re-run the sequence.
- pll_rst  out  1  reset to the PLL.
- sys_rst_req  out  1  system reset request; high until lock is qualified.
- ready  out  1  PLL locked and stable; equals !sys_rst_req && !fault.
- fault  out  1  retries exhausted.
- retry_cnt  out  2  attempts consumed in the current sequence.
- lock_loss_cnt  out  8  lock losses seen in RUN; saturates at 255.

Behaviour:
- Reset (async assert):
  - state=HOLD, counter=0, retry_cnt=0, lock_loss_cnt=0, sync flops=0.
  - pll_rst=1, sys_rst_req=1, ready=0, fault=0.
  - Reset deassertion is taken synchronously at the next refclk edge.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- HOLD:
  - pll_rst=1, sys_rst_req=1.
  - The counter increments each cycle. At counter==RST_HOLD_CYCLES-1, go to WAIT_LOCK and clear the counter.
  - pll_rst is therefore high for exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_req=1.
  - If locked_s=1: go to STABLE and clear the counter. Lock wins over a simultaneous timeout.
  - Else if counter==LOCK_TIMEOUT-1 and retry_cnt==MAX_RETRIES: go to FAULT.
  - Else if counter==LOCK_TIMEOUT-1: increment retry_cnt and go to HOLD with counter=0.
- STABLE:
  - pll_rst=0, sys_rst_req=1.
  - If locked_s=0: go to WAIT_LOCK with counter=0. A glitch does not consume a retry.
  - Else at counter==LOCK_STABLE_CYCLES-1: go to RUN.
- RUN:
  - pll_rst=0, sys_rst_req=0, ready=1.
  - If locked_s=0: go to HOLD, increment lock_loss_cnt (saturating), clear retry_cnt, clear counter.
  - Else if relock_req=1: go to HOLD, clear retry_cnt, leave lock_loss_cnt unchanged.
  - If lock loss and relock_req occur in the same cycle, take the loss path; the counter increments once.
- FAULT:
  - pll_rst=1, sys_rst_req=1, fault=1.
  - Stays in FAULT until relock_req=1, then goes to HOLD with retry_cnt=0 and fault=0 on the same edge.
- relock_req is ignored in HOLD, WAIT_LOCK and STABLE.
- Latency from pll_locked rising (held) in WAIT_LOCK to ready=1: 2 sync cycles + 1 transition cycle + LOCK_STABLE_CYCLES.
- Latency from pll_locked falling in RUN to sys_rst_req=1: 3 cycles (2 sync + 1 register).
- Total attempts before FAULT: MAX_RETRIES+1.

Decomposition:
- Package uart_io_pll_pkg holds:
  - state enum: HOLD, WAIT_LOCK, STABLE, RUN, FAULT (3-bit);
  - default parameter constants;
  - LOSS_CNT_MAX=255.
- Sub-module uart_io_sync2: generic 2-flop bit synchronizer with async active-high reset to 0. Used for pll_locked.
- Everything else is one FSM plus one shared counter in the top module.

Test Plan (RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2):
- Nominal bring-up: release rst; raise pll_locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready=1 and sys_rst_req=0 exactly 11 cycles after the pll_locked rise; retry_cnt=0.
- Timeout/fault: hold pll_locked=0 -> 3 HOLD pulses of 4 cycles each separated by 20-cycle WAIT_LOCK windows; retry_cnt goes 1 then 2; fault=1 and pll_rst=1 after the third timeout.
- Recovery: while in FAULT, pulse relock_req, then raise pll_locked -> fault=0, retry_cnt=0, new 4-cycle pll_rst pulse, then ready=1.
- Glitch during STABLE: drop pll_locked for 1 cycle at stable count 5 -> returns to WAIT_LOCK, retry_cnt unchanged; ready only after a further full 8 stable cycles.
- Loss in RUN: drop pll_locked while ready=1 -> sys_rst_req=1 three cycles later, lock_loss_cnt=1, pll_rst pulse; repeat 300 times -> lock_loss_cnt saturates at 255.
- Async reset mid-WAIT_LOCK with retry_cnt=1 -> outputs return immediately (no clock edge) to pll_rst=1, sys_rst_req=1, retry_cnt=0, lock_loss_cnt=0.
